operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side client of the 16-entry, 32-bit CPU register file, which has 1-cycle synchronous read latency.
- Accepts decoded operand requests (two source indices plus a tag) over a valid/ready handshake and drives the register-file read indices.
- Captures the returned read data, applies bypass from the write bus, and presents both operands downstream over valid/ready.
- Sits between decode and execute.

Parameters:
- DATA_WIDTH, 32, operand/register width.
- IDX_WIDTH, 4, register index width (16 registers).
- TAG_WIDTH, 8, opaque tag carried with each request.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_idx_a  in  IDX_WIDTH  source register A.
- req_idx_b  in  IDX_WIDTH  source register B.
- req_tag  in  TAG_WIDTH  request tag.
- rf_idx_a  out  IDX_WIDTH  register-file read index A.
- rf_idx_b  out  IDX_WIDTH  register-file read index B.
- rf_data_a  in  DATA_WIDTH  register-file read data A (1 cycle after index).
- rf_data_b  in  DATA_WIDTH  register-file read data B.
- wb_en  in  1  register-file write enable (snooped).
- wb_idx  in  IDX_WIDTH  write index (snooped).
- wb_data  in  DATA_WIDTH  write data (snooped).
- out_valid  out  1  operands valid.
- out_ready  in  1  consumer accepts.
- out_a  out  DATA_WIDTH  operand A.
- out_b  out  DATA_WIDTH  operand B.
- out_tag  out  TAG_WIDTH  tag.

Behaviour:
- Two stages.
  - S1 (read issued): s1_valid, s1_idx_a/b, s1_tag.
  - S2 (output): out_valid, out_a/b, out_tag.
- Reset (async): s1_valid=0, out_valid=0, out_a=out_b=0, out_tag=0, wb snoop registers cleared, wbq_en=0.
- s2_free = !out_valid | out_ready. req_ready = !s1_valid | s2_free (combinational).
- rf_idx_a/b = req_idx_a/b when the request is accepted, else s1_idx_a/b. A stalled S1 re-reads every cycle.
- Write snoop: every cycle register wbq_en/wbq_idx/wbq_data <= wb_en/wb_idx/wb_data.
- S1 operand X = (wbq_en & wbq_idx==s1_idx_x) ? wbq_data : rf_data_x. This covers a write landing on the same edge as the read.
- S1→S2 when s1_valid & s2_free: out_* <= S1 operands; if wb_en & wb_idx matches, wb_data is used instead (write landing this edge).
- Held S2 (out_valid & !out_ready): on wb_en & wb_idx==index of out_a (and/or out_b), replace that operand with wb_data. Writes always come from older instructions. S2 therefore stores its indices.
- Latency: request accept → out_valid = 2 cycles. Throughput 1 per cycle with out_ready held high.
- out_valid deasserts only after out_ready handshake with no S1 entry advancing.
- idx_a==idx_b: both operands are identical, including bypass.
- Simultaneous accept, advance and write in one cycle is legal; every stage applies the bypass independently.
- rst mid-operation drops all in-flight requests; no output is produced.

Optional Feature:
- Macro OPFETCH_ZERO_REG_EN.
- Defined: index 0 always yields 0 on out_a/out_b regardless of rf data, bypass or write snoop. Writes to index 0 are never bypassed.
- Undefined: register 0 is treated like any other register.

Decomposition:
- Shared package cpu_rf_pkg: RF_DATA_WIDTH=32, RF_IDX_WIDTH=4, RF_NUM_REGS=16, ZERO_REG_IDX=0.
- One natural sub-module: operand_bypass_mux, a per-operand select of rf data / registered write / live write, plus the zero-register override. Instantiate it twice.

Test Plan:
- Basic read: preload r3=0x1111_2222, r5=0xA5A5_0000; request (3,5,tag 0x07) with out_ready=1 → 2 cycles later out_valid=1, out_a=0x1111_2222, out_b=0xA5A5_0000, out_tag=0x07.
- Same-edge bypass: write r3=0xDEAD_BEEF on the same edge the read of r3 is issued → out_a=0xDEAD_BEEF, not the stale value.
- Back-pressure: out_ready=0 for 5 cycles with 3 requests offered → at most 2 accepted, req_ready=0 afterwards. Release → 3 outputs in order, no loss or duplication.
- Held-operand update: out_valid=1 for (r4,r4), out_ready=0; write r4=0x0000_0042 → out_a=out_b=0x0000_0042 the next cycle.
- Async reset: assert rst mid-stream between clock edges → out_valid=0, req_ready=1 immediately. No output after deassert until a new request arrives.
- Zero register (macro defined): write r0=0xFFFF_FFFF, then request (0,0) → out_a=out_b=0. Macro undefined → 0xFFFF_FFFF.

Source files
------------

// File: rtl/cpu_rf_pkg.sv
// -----------------------------------------------------------------------------
// cpu_rf_pkg
// Shared definitions for clients of the 16-entry, 32-bit CPU register file.
//
// Contents:
//   RF_DATA_WIDTH / RF_IDX_WIDTH / RF_NUM_REGS : register-file geometry
//   ZERO_REG_IDX                               : index of the hard-wired zero register
//   ZERO_REG_EN                                : 1 when OPFETCH_ZERO_REG_EN is defined
//   is_zero_reg()                              : index reads as constant zero
//   bypass_hit()                               : snooped write targets a read index
//
// Build option: OPFETCH_ZERO_REG_EN makes register 0 read as zero and
// excludes it from every bypass path.
// -----------------------------------------------------------------------------
package cpu_rf_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_IDX_WIDTH  = 4;
   localparam int RF_NUM_REGS   = 16;

   localparam logic [RF_IDX_WIDTH-1:0] ZERO_REG_IDX = 4'd0;

`ifdef OPFETCH_ZERO_REG_EN
   localparam logic ZERO_REG_EN = 1'b1;
`else
   localparam logic ZERO_REG_EN = 1'b0;
`endif

   // True when the index is the hard-wired zero register (only with the option on).
   function automatic logic is_zero_reg(input logic [RF_IDX_WIDTH-1:0] idx);
      return ZERO_REG_EN & (idx == ZERO_REG_IDX);
   endfunction

   // A write is forwarded only to a matching index that is not the zero register.
   function automatic logic bypass_hit(input logic                    en,
                                       input logic [RF_IDX_WIDTH-1:0] wr_idx,
                                       input logic [RF_IDX_WIDTH-1:0] rd_idx);
      return en & (wr_idx == rd_idx) & ~is_zero_reg(rd_idx);
   endfunction

endpackage : cpu_rf_pkg

// File: rtl/operand_bypass_mux.sv
// -----------------------------------------------------------------------------
// operand_bypass_mux
// Per-operand source select for the S1->S2 transfer of operand_fetch.
//
// Ports:
//   rd_idx    in  register index of this operand
//   rf_data   in  register-file read data for rd_idx (read issued last edge)
//   wbq_en/idx/data in  write that landed on the edge the read was sampled
//   wb_en/idx/data  in  write landing on the coming edge
//   op        out value to load into the output stage
//
// Priority: zero register, then live write (youngest), then registered write,
// then register-file data.
// -----------------------------------------------------------------------------
module operand_bypass_mux
   import cpu_rf_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int IDX_WIDTH  = RF_IDX_WIDTH
) (
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   input  logic [DATA_WIDTH-1:0] rf_data,
   input  logic                  wbq_en,
   input  logic [IDX_WIDTH-1:0]  wbq_idx,
   input  logic [DATA_WIDTH-1:0] wbq_data,
   input  logic                  wb_en,
   input  logic [IDX_WIDTH-1:0]  wb_idx,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [DATA_WIDTH-1:0] op
);

   // Select the newest value of the register, or zero for the zero register.
   always_comb begin
      op = rf_data;
      if (is_zero_reg(rd_idx)) begin
         op = {DATA_WIDTH{1'b0}};
      end else if (bypass_hit(wb_en, wb_idx, rd_idx)) begin
         op = wb_data;
      end else if (bypass_hit(wbq_en, wbq_idx, rd_idx)) begin
         // The register file returned the pre-write value on that edge.
         op = wbq_data;
      end else begin
         op = rf_data;
      end
   end

endmodule : operand_bypass_mux

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Read-side client of the CPU register file (1-cycle synchronous read).
// Accepts (idx_a, idx_b, tag) requests, issues register-file reads, applies
// write-bus bypass and presents both operands downstream. Two stages:
// S1 = read in flight, S2 = output register.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake; req_idx_a/b, req_tag payload
//   rf_idx_a/b               register-file read indices (combinational)
//   rf_data_a/b              register-file read data, one cycle after index
//   wb_en/wb_idx/wb_data     snooped register-file write port
//   out_valid/out_ready      output handshake; out_a/out_b/out_tag payload
//
// Build option: OPFETCH_ZERO_REG_EN -- register 0 always reads as zero.
// -----------------------------------------------------------------------------
module operand_fetch
   import cpu_rf_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int IDX_WIDTH  = RF_IDX_WIDTH,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IDX_WIDTH-1:0]  req_idx_a,
   input  logic [IDX_WIDTH-1:0]  req_idx_b,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic [IDX_WIDTH-1:0]  rf_idx_a,
   output logic [IDX_WIDTH-1:0]  rf_idx_b,
   input  logic [DATA_WIDTH-1:0] rf_data_a,
   input  logic [DATA_WIDTH-1:0] rf_data_b,
   input  logic                  wb_en,
   input  logic [IDX_WIDTH-1:0]  wb_idx,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   logic                  s1_valid_q, s1_valid_d;
   logic [IDX_WIDTH-1:0]  s1_idx_a_q, s1_idx_a_d, s1_idx_b_q, s1_idx_b_d;
   logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
   logic [IDX_WIDTH-1:0]  s2_idx_a_q, s2_idx_a_d, s2_idx_b_q, s2_idx_b_d;

   logic                  wbq_en_q, wbq_en_d;
   logic [IDX_WIDTH-1:0]  wbq_idx_q, wbq_idx_d;
   logic [DATA_WIDTH-1:0] wbq_data_q, wbq_data_d;

   logic                  s2_free, accept, advance;
   logic [DATA_WIDTH-1:0] adv_a, adv_b;

   // Handshake control and read-index steering.
   always_comb begin
      s2_free   = ~out_valid_q | out_ready;
      req_ready = ~s1_valid_q | s2_free;
      accept    = req_valid & req_ready;
      advance   = s1_valid_q & s2_free;
      // A stalled S1 keeps re-reading its own indices every cycle.
      rf_idx_a  = accept ? req_idx_a : s1_idx_a_q;
      rf_idx_b  = accept ? req_idx_b : s1_idx_b_q;
   end

   operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_mux_a (
      .rd_idx  (s1_idx_a_q),
      .rf_data (rf_data_a),
      .wbq_en  (wbq_en_q),
      .wbq_idx (wbq_idx_q),
      .wbq_data(wbq_data_q),
      .wb_en   (wb_en),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .op      (adv_a)
   );

   operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_mux_b (
      .rd_idx  (s1_idx_b_q),
      .rf_data (rf_data_b),
      .wbq_en  (wbq_en_q),
      .wbq_idx (wbq_idx_q),
      .wbq_data(wbq_data_q),
      .wb_en   (wb_en),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .op      (adv_b)
   );

   // S1 next state and write-snoop capture.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_idx_a_d = s1_idx_a_q;
      s1_idx_b_d = s1_idx_b_q;
      s1_tag_d   = s1_tag_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_idx_a_d = req_idx_a;
         s1_idx_b_d = req_idx_b;
         s1_tag_d   = req_tag;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      wbq_en_d   = wb_en;
      wbq_idx_d  = wb_idx;
      wbq_data_d = wb_data;
   end

   // S2 next state: load from S1, drain on handshake, or refresh held operands.
   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_tag_d   = out_tag_q;
      s2_idx_a_d  = s2_idx_a_q;
      s2_idx_b_d  = s2_idx_b_q;
      if (advance) begin
         out_valid_d = 1'b1;
         out_a_d     = adv_a;
         out_b_d     = adv_b;
         out_tag_d   = s1_tag_q;
         s2_idx_a_d  = s1_idx_a_q;
         s2_idx_b_d  = s1_idx_b_q;
      end else if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q) begin
         // Held result: writes come from older instructions, so track them.
         if (bypass_hit(wb_en, wb_idx, s2_idx_a_q)) begin
            out_a_d = wb_data;
         end else begin
            out_a_d = out_a_q;
         end
         if (bypass_hit(wb_en, wb_idx, s2_idx_b_q)) begin
            out_b_d = wb_data;
         end else begin
            out_b_d = out_b_q;
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // Pipeline state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_idx_a_q  <= {IDX_WIDTH{1'b0}};
         s1_idx_b_q  <= {IDX_WIDTH{1'b0}};
         s1_tag_q    <= {TAG_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         out_a_q     <= {DATA_WIDTH{1'b0}};
         out_b_q     <= {DATA_WIDTH{1'b0}};
         out_tag_q   <= {TAG_WIDTH{1'b0}};
         s2_idx_a_q  <= {IDX_WIDTH{1'b0}};
         s2_idx_b_q  <= {IDX_WIDTH{1'b0}};
         wbq_en_q    <= 1'b0;
         wbq_idx_q   <= {IDX_WIDTH{1'b0}};
         wbq_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_idx_a_q  <= s1_idx_a_d;
         s1_idx_b_q  <= s1_idx_b_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_tag_q   <= out_tag_d;
         s2_idx_a_q  <= s2_idx_a_d;
         s2_idx_b_q  <= s2_idx_b_d;
         wbq_en_q    <= wbq_en_d;
         wbq_idx_q   <= wbq_idx_d;
         wbq_data_q  <= wbq_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_tag   = out_tag_q;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Bench for operand_fetch. Contains a register-file model (1-cycle read,
// read-before-write on the same edge). Reference rule: every operand handed
// over on an output handshake equals the architectural register value at
// that moment (all writes landed so far), and results leave in request order.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_idx_a;
   logic [3:0]  req_idx_b;
   logic [7:0]  req_tag;
   logic [3:0]  rf_idx_a;
   logic [3:0]  rf_idx_b;
   logic [31:0] rf_data_a;
   logic [31:0] rf_data_b;
   logic        wb_en;
   logic [3:0]  wb_idx;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [7:0]  out_tag;

   int n_vec;
   int n_err;

`ifdef OPFETCH_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] tag;
   } req_t;

   req_t sb_q[$];

   logic [31:0] rf_mem [16];

   operand_fetch dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_idx_a(req_idx_a),
      .req_idx_b(req_idx_b),
      .req_tag  (req_tag),
      .rf_idx_a (rf_idx_a),
      .rf_idx_b (rf_idx_b),
      .rf_data_a(rf_data_a),
      .rf_data_b(rf_data_b),
      .wb_en    (wb_en),
      .wb_idx   (wb_idx),
      .wb_data  (wb_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_a    (out_a),
      .out_b    (out_b),
      .out_tag  (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: synchronous read returns the pre-write contents.
   always @(posedge clk) begin
      rf_data_a <= rf_mem[rf_idx_a];
      rf_data_b <= rf_mem[rf_idx_b];
      if (wb_en) rf_mem[wb_idx] <= wb_data;
   end

   // Architectural value a consumer must see for a register right now.
   function automatic logic [31:0] exp_val(input logic [3:0] idx);
      if (ZERO_EN && idx == 4'd0) return 32'h0000_0000;
      return rf_mem[idx];
   endfunction

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
      wb_en = 1'b1; wb_idx = idx; wb_data = data;
      next_cycle();
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      n_vec++; if (out_a !== 32'h0 || out_b !== 32'h0) begin n_err++; $display("FAIL reset_out_ab got %h/%h expected 0/0", out_a, out_b); end
      n_vec++; if (out_tag !== 8'h00) begin n_err++; $display("FAIL reset_out_tag got %h expected 00", out_tag); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_basic_read();
      do_write(4'd3, 32'h1111_2222);
      do_write(4'd5, 32'hA5A5_0000);
      req_valid = 1'b1; req_idx_a = 4'd3; req_idx_b = 4'd5; req_tag = 8'h07; out_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL basic_req_ready got %b expected 1", req_ready); end
      n_vec++; if (rf_idx_a !== 4'd3 || rf_idx_b !== 4'd5) begin n_err++; $display("FAIL basic_rf_idx got %0d/%0d expected 3/5", rf_idx_a, rf_idx_b); end
      next_cycle();
      req_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b expected 0", out_valid); end
      next_cycle();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got %b expected 1", out_valid); end
      n_vec++; if (out_a !== 32'h1111_2222) begin n_err++; $display("FAIL basic_out_a got %h expected 11112222", out_a); end
      n_vec++; if (out_b !== 32'hA5A5_0000) begin n_err++; $display("FAIL basic_out_b got %h expected a5a50000", out_b); end
      n_vec++; if (out_tag !== 8'h07) begin n_err++; $display("FAIL basic_out_tag got %h expected 07", out_tag); end
      next_cycle();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b expected 0", out_valid); end
   endtask

   task automatic test_same_edge_bypass();
      // Write r3 on the edge that samples the read of r3.
      req_valid = 1'b1; req_idx_a = 4'd3; req_idx_b = 4'd5; req_tag = 8'h11; out_ready = 1'b1;
      wb_en = 1'b1; wb_idx = 4'd3; wb_data = 32'hDEAD_BEEF;
      next_cycle();
      // Write r5 on the edge that moves the request into the output stage.
      req_valid = 1'b0; wb_en = 1'b1; wb_idx = 4'd5; wb_data = 32'h0BAD_F00D;
      next_cycle();
      wb_en = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid got %b expected 1", out_valid); end
      n_vec++; if (out_a !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_same_edge_a got %h expected deadbeef", out_a); end
      n_vec++; if (out_b !== 32'h0BAD_F00D) begin n_err++; $display("FAIL bypass_live_b got %h expected 0badf00d", out_b); end
      n_vec++; if (out_tag !== 8'h11) begin n_err++; $display("FAIL bypass_tag got %h expected 11", out_tag); end
      next_cycle();
   endtask

   task automatic test_back_pressure();
      req_t reqs[3];
      req_t e;
      int sent;
      int got;
      reqs[0] = '{a: 4'd1, b: 4'd2, tag: 8'hB0};
      reqs[1] = '{a: 4'd2, b: 4'd6, tag: 8'hB1};
      reqs[2] = '{a: 4'd7, b: 4'd7, tag: 8'hB2};
      sent = 0; got = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         req_valid = (sent < 3);
         if (sent < 3) begin
            req_idx_a = reqs[sent].a; req_idx_b = reqs[sent].b; req_tag = reqs[sent].tag;
         end
         #1;
         if (c == 5) begin
            n_vec++; if (sent != 2) begin n_err++; $display("FAIL bp_accept_count got %0d expected 2", sent); end
            n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready got %b expected 0", req_ready); end
         end else if (req_valid && req_ready) begin
            sb_q.push_back(reqs[sent]);
            sent++;
            next_cycle();
         end else begin
            next_cycle();
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 3; c++) begin
         req_valid = (sent < 3);
         if (sent < 3) begin
            req_idx_a = reqs[sent].a; req_idx_b = reqs[sent].b; req_tag = reqs[sent].tag;
         end
         #1;
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL bp_spurious_output tag %h expected none", out_tag);
            end else begin
               e = sb_q.pop_front();
               if (out_tag !== e.tag || out_a !== exp_val(e.a) || out_b !== exp_val(e.b)) begin
                  n_err++;
                  $display("FAIL bp_output got %h/%h/%h expected %h/%h/%h", out_tag, out_a, out_b, e.tag, exp_val(e.a), exp_val(e.b));
               end
            end
            got++;
         end
         if (req_valid && req_ready) begin
            sb_q.push_back(reqs[sent]);
            sent++;
         end
         next_cycle();
      end
      req_valid = 1'b0;
      n_vec++; if (got != 3 || sent != 3) begin n_err++; $display("FAIL bp_totals got %0d out/%0d in expected 3/3", got, sent); end
      for (int c = 0; c < 3; c++) begin
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_duplicate got out_valid %b expected 0", out_valid); end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] etag;
      logic [3:0] ea;
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         req_valid = (c < 4);
         req_idx_a = 4'(c + 8); req_idx_b = 4'(c + 9); req_tag = 8'(8'hD0 + c);
         #1;
         if (c < 4) begin
            n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready cycle %0d got %b expected 1", c, req_ready); end
         end
         if (c >= 2 && c < 6) begin
            etag = 8'(8'hD0 + c - 2);
            ea = 4'(c - 2 + 8);
            n_vec++;
            if (out_valid !== 1'b1 || out_tag !== etag || out_a !== exp_val(ea)) begin
               n_err++;
               $display("FAIL b2b_output cycle %0d got %b/%h/%h expected 1/%h/%h", c, out_valid, out_tag, out_a, etag, exp_val(ea));
            end
         end
         if (c == 6) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b expected 0", out_valid); end
         end
         next_cycle();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_held_update();
      req_valid = 1'b1; req_idx_a = 4'd4; req_idx_b = 4'd4; req_tag = 8'h44; out_ready = 1'b0;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      n_vec++;
      if (out_valid !== 1'b1 || out_a !== exp_val(4'd4)) begin
         n_err++; $display("FAIL held_initial got %b/%h expected 1/%h", out_valid, out_a, exp_val(4'd4));
      end
      do_write(4'd4, 32'h0000_0042);
      n_vec++; if (out_a !== 32'h0000_0042) begin n_err++; $display("FAIL held_update_a got %h expected 00000042", out_a); end
      n_vec++; if (out_b !== 32'h0000_0042) begin n_err++; $display("FAIL held_update_b got %h expected 00000042", out_b); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL held_still_valid got %b expected 1", out_valid); end
      out_ready = 1'b1;
      next_cycle();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL held_release got %b expected 0", out_valid); end
   endtask

   task automatic test_zero_reg();
      logic [31:0] exp0;
      do_write(4'd0, 32'hFFFF_FFFF);
      req_valid = 1'b1; req_idx_a = 4'd0; req_idx_b = 4'd0; req_tag = 8'h5A; out_ready = 1'b1;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      exp0 = ZERO_EN ? 32'h0000_0000 : 32'hFFFF_FFFF;
      n_vec++; if (out_a !== exp0 || out_b !== exp0) begin n_err++; $display("FAIL zero_reg_read got %h/%h expected %h", out_a, out_b, exp0); end
      // Same-edge write to r0 must not leak through the bypass when r0 is hard-wired.
      req_valid = 1'b1; req_idx_a = 4'd0; req_idx_b = 4'd3; req_tag = 8'h5B;
      wb_en = 1'b1; wb_idx = 4'd0; wb_data = 32'h1234_5678;
      next_cycle();
      req_valid = 1'b0; wb_en = 1'b0;
      next_cycle();
      exp0 = ZERO_EN ? 32'h0000_0000 : 32'h1234_5678;
      n_vec++; if (out_a !== exp0) begin n_err++; $display("FAIL zero_reg_bypass got %h expected %h", out_a, exp0); end
      n_vec++; if (out_b !== exp_val(4'd3)) begin n_err++; $display("FAIL zero_reg_other got %h expected %h", out_b, exp_val(4'd3)); end
      next_cycle();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      req_valid = 1'b1; req_idx_a = 4'd1; req_idx_b = 4'd2; req_tag = 8'hC1;
      next_cycle();
      req_tag = 8'hC2;
      next_cycle();
      req_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b expected 0", out_valid); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL arst_req_ready got %b expected 1", req_ready); end
      next_cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_ghost_output cycle %0d got %b expected 0", c, out_valid); end
      end
      req_valid = 1'b1; req_idx_a = 4'd9; req_idx_b = 4'd10; req_tag = 8'hC3;
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      n_vec++;
      if (out_valid !== 1'b1 || out_tag !== 8'hC3 || out_a !== exp_val(4'd9) || out_b !== exp_val(4'd10)) begin
         n_err++; $display("FAIL arst_recover got %b/%h/%h/%h expected 1/c3/%h/%h", out_valid, out_tag, out_a, out_b, exp_val(4'd9), exp_val(4'd10));
      end
      next_cycle();
   endtask

   task automatic test_random();
      req_t e;
      req_t r;
      for (int c = 0; c < 460; c++) begin
         if (c < 400) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_idx_a = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            req_idx_b = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            req_tag   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            wb_en     = $urandom_range(0, 1) ? 1'b1 : 1'b0;
            wb_idx    = 4'($urandom_range(0, 3));
            wb_data   = $urandom;
         end else begin
            req_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL rand_spurious_output cycle %0d tag %h", c, out_tag);
            end else begin
               e = sb_q.pop_front();
               if (out_tag !== e.tag || out_a !== exp_val(e.a) || out_b !== exp_val(e.b)) begin
                  n_err++;
                  $display("FAIL rand_output cycle %0d got %h/%h/%h expected %h/%h/%h", c, out_tag, out_a, out_b, e.tag, exp_val(e.a), exp_val(e.b));
               end
            end
         end
         if (req_valid && req_ready) begin
            r.a = req_idx_a; r.b = req_idx_b; r.tag = req_tag;
            sb_q.push_back(r);
         end
         next_cycle();
      end
      n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL rand_lost_results got %0d pending expected 0", sb_q.size()); end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_idx_a = 4'd0; req_idx_b = 4'd0; req_tag = 8'h00;
      wb_en = 1'b0; wb_idx = 4'd0; wb_data = 32'h0; out_ready = 1'b0;
      test_reset();
      for (int i = 0; i < 16; i++) do_write(4'(i), $urandom);
      test_basic_read();
      test_same_edge_bypass();
      test_back_pressure();
      test_back_to_back();
      test_held_update();
      test_zero_reg();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_operand_fetch
